// File: rtl/ark_engine.sv
// Round-key XOR engine: state ^ key_store[rcnt], 1-cycle latency (2 with ARK_OUT_REG_EN), full throughput.
// Backpressure: valid/ready; results hold while out_ready is low, enable low freezes all but key writes.
module ark_engine #(
   parameter  int WORD_SIZE     = 8,
   parameter  int ROWS          = 4,
   parameter  int ROUNDS        = 11,
   parameter  int KEY_TRANSPOSE = 1,
   localparam int ARRAY_SIZE    = ROWS * ROWS,
   localparam int DW            = WORD_SIZE * ARRAY_SIZE,
   localparam int AW            = $clog2(ROUNDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          restart,
   input  logic          key_we,
   input  logic [AW-1:0] key_addr,
   input  logic [DW-1:0] key,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] state,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] state_out,
   output logic [AW-1:0] out_round,
   output logic          out_last
);

   logic [DW-1:0] store_q [ROUNDS];
   logic [DW-1:0] store_d [ROUNDS];
   logic [AW-1:0] rcnt_q, rcnt_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] state_out_q, state_out_d;
   logic [AW-1:0] out_round_q, out_round_d;
   logic          out_last_q, out_last_d;

   logic          accept;
   logic [AW-1:0] rsel;
   logic [AW-1:0] rcnt_inc;
   logic [DW-1:0] key_raw;
   logic [DW-1:0] key_map;
   logic [DW-1:0] res;
   logic          res_last;

`ifdef ARK_OUT_REG_EN
   logic          s1_valid_q, s1_valid_d;
   logic [DW-1:0] s1_dat_q, s1_dat_d;
   logic [AW-1:0] s1_round_q, s1_round_d;
   logic          s1_last_q, s1_last_d;
   logic          out_move;

   // Stage 1 only blocks input when both entries are occupied and the output is stalled.
   assign in_ready = enable & ~(s1_valid_q & out_valid_q & ~out_ready);
   assign out_move = ~out_valid_q | out_ready;
`else
   assign in_ready = enable & (~out_valid_q | out_ready);
`endif

   assign accept   = in_valid & in_ready;
   assign rsel     = restart ? '0 : rcnt_q;
   assign key_raw  = store_q[rsel];
   assign res      = state ^ key_map;
   assign res_last = (rsel == AW'(ROUNDS - 1));
   assign rcnt_inc = (rcnt_q == AW'(ROUNDS - 1)) ? '0 : rcnt_q + AW'(1);

   always_comb begin
      key_map = '0;
      for (int j = 0; j < ARRAY_SIZE; j++) begin
         key_map[j*WORD_SIZE +: WORD_SIZE] =
            key_raw[((KEY_TRANSPOSE != 0) ? ((j % ROWS) * ROWS + j / ROWS) : j) * WORD_SIZE +: WORD_SIZE];
      end
   end

   always_comb begin
      store_d     = store_q;
      rcnt_d      = rcnt_q;
      out_valid_d = out_valid_q;
      state_out_d = state_out_q;
      out_round_d = out_round_q;
      out_last_d  = out_last_q;
`ifdef ARK_OUT_REG_EN
      s1_valid_d  = s1_valid_q;
      s1_dat_d    = s1_dat_q;
      s1_round_d  = s1_round_q;
      s1_last_d   = s1_last_q;
`endif
      // Out-of-range addresses match no entry and are dropped.
      for (int i = 0; i < ROUNDS; i++) begin
         if (key_we && key_addr == AW'(i)) store_d[i] = key;
      end
      if (enable) begin
         if (accept)       rcnt_d = restart ? AW'(1) : rcnt_inc;
         else if (restart) rcnt_d = '0;
`ifdef ARK_OUT_REG_EN
         if (out_move) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
               state_out_d = s1_dat_q;
               out_round_d = s1_round_q;
               out_last_d  = s1_last_q;
            end
         end
         if (accept) begin
            s1_valid_d = 1'b1;
            s1_dat_d   = res;
            s1_round_d = rsel;
            s1_last_d  = res_last;
         end else if (out_move) begin
            s1_valid_d = 1'b0;
         end
`else
         if (accept) begin
            out_valid_d = 1'b1;
            state_out_d = res;
            out_round_d = rsel;
            out_last_d  = res_last;
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROUNDS; i++) store_q[i] <= '0;
         rcnt_q      <= '0;
         out_valid_q <= 1'b0;
         state_out_q <= '0;
         out_round_q <= '0;
         out_last_q  <= 1'b0;
`ifdef ARK_OUT_REG_EN
         s1_valid_q  <= 1'b0;
         s1_dat_q    <= '0;
         s1_round_q  <= '0;
         s1_last_q   <= 1'b0;
`endif
      end else begin
         store_q     <= store_d;
         rcnt_q      <= rcnt_d;
         out_valid_q <= out_valid_d;
         state_out_q <= state_out_d;
         out_round_q <= out_round_d;
         out_last_q  <= out_last_d;
`ifdef ARK_OUT_REG_EN
         s1_valid_q  <= s1_valid_d;
         s1_dat_q    <= s1_dat_d;
         s1_round_q  <= s1_round_d;
         s1_last_q   <= s1_last_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign state_out = state_out_q;
   assign out_round = out_round_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_ark_engine.sv
// Randomized bench for ark_engine (default parameters) against a queue-based reference model.
module tb_ark_engine;
   localparam int W  = 8;
   localparam int R  = 4;
   localparam int N  = 11;
   localparam int E  = R * R;
   localparam int DW = W * E;
   localparam int AW = $clog2(N);
`ifdef ARK_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst, enable, restart, key_we, in_valid, out_ready;
   logic [AW-1:0] key_addr;
   logic [DW-1:0] key, state;
   logic          in_ready, out_valid, out_last;
   logic [DW-1:0] state_out;
   logic [AW-1:0] out_round;

   ark_engine dut (
      .clk(clk), .rst(rst), .enable(enable), .restart(restart),
      .key_we(key_we), .key_addr(key_addr), .key(key),
      .in_valid(in_valid), .in_ready(in_ready), .state(state),
      .out_valid(out_valid), .out_ready(out_ready),
      .state_out(state_out), .out_round(out_round), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [AW-1:0] rnd;
      logic          last;
   } exp_t;

   exp_t          sb [$];
   logic [DW-1:0] mdl_store [N];
   int            mdl_rcnt;
   int            n_vec, n_err, n_take, n_last;

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Effective key seen by the XOR: element j comes from raw element (j%R)*R + j/R.
   function automatic logic [DW-1:0] eff_key(input logic [DW-1:0] raw);
      logic [DW-1:0] r;
      r = '0;
      for (int j = 0; j < E; j++) r[j*W +: W] = raw[((j % R) * R + j / R) * W +: W];
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: sample just after inputs settle, update the model, advance to next negedge.
   task automatic cycle();
      logic exp_rdy, acc, take;
      int   r;
      exp_t e;
      #1;
      if (rst) begin
         sb.delete();
         mdl_rcnt = 0;
         for (int i = 0; i < N; i++) mdl_store[i] = '0;
      end else begin
`ifdef ARK_OUT_REG_EN
         exp_rdy = enable && !(sb.size() >= 2 && !out_ready);
         take    = enable && out_ready && out_valid;
`else
         exp_rdy = enable && (sb.size() == 0 || out_ready);
         take    = enable && out_ready && sb.size() > 0;
         check_val("out_valid", DW'(out_valid), DW'(sb.size() > 0));
`endif
         check_val("in_ready", DW'(in_ready), DW'(exp_rdy));
         acc = in_valid && exp_rdy;
         if (take) begin
            if (sb.size() == 0) check_val("sb_occupancy", DW'(sb.size()), DW'(1));
            else begin
               e = sb.pop_front();
               check_val("state_out", state_out, e.d);
               check_val("out_round", DW'(out_round), DW'(e.rnd));
               check_val("out_last", DW'(out_last), DW'(e.last));
               n_take++;
               if (e.last) n_last++;
            end
         end
         if (enable) begin
            if (acc) begin
               r      = restart ? 0 : mdl_rcnt;
               e.d    = state ^ eff_key(mdl_store[r]);
               e.rnd  = AW'(r);
               e.last = (r == N - 1);
               sb.push_back(e);
               mdl_rcnt = restart ? 1 : (mdl_rcnt + 1) % N;
            end else if (restart) begin
               mdl_rcnt = 0;
            end
         end
         if (key_we && int'(key_addr) < N) mdl_store[key_addr] = key;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      restart = 0; key_we = 0; in_valid = 0;
   endtask

   task automatic drain();
      idle_inputs();
      out_ready = 1;
      for (int i = 0; i < 4; i++) cycle();
   endtask

   logic [DW-1:0] aes_k, aes_s, ramp, held, newkey;
   int            lat, t0, l0;

   initial begin
      n_vec = 0; n_err = 0; n_take = 0; n_last = 0; mdl_rcnt = 0;
      rst = 1; enable = 1; out_ready = 1; key_addr = '0; key = '0; state = '0;
      idle_inputs();
      @(negedge clk);
      cycle();
      cycle();
      rst = 0;
      check_val("rst_out_valid", DW'(out_valid), DW'(0));
      check_val("rst_state_out", state_out, '0);
      check_val("rst_out_round", DW'(out_round), DW'(0));
      check_val("rst_out_last", DW'(out_last), DW'(0));
      check_val("rst_in_ready", DW'(in_ready), DW'(1));

      // Known-answer vector; the store holds the transposed key so the effective key is aes_k.
      aes_k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      aes_s = 128'h3243f6a8885a308d313198a2e0370734;
      key_we = 1; key_addr = '0; key = eff_key(aes_k);
      cycle();
      key_we = 0; in_valid = 1; state = aes_s;
      cycle();
      in_valid = 0; lat = 1;
      while (!out_valid && lat < 5) begin cycle(); lat++; end
      check_val("kat_latency", DW'(lat), DW'(LAT));
      check_val("kat_state_out", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      check_val("kat_round", DW'(out_round), DW'(0));
      drain();

      // Transpose mapping: element i of store[0] = i, state 0.
      for (int i = 0; i < E; i++) ramp[i*W +: W] = W'(i);
      key_we = 1; key_addr = '0; key = ramp;
      cycle();
      key_we = 0; restart = 1; in_valid = 1; state = '0;
      cycle();
      idle_inputs(); lat = 1;
      while (!out_valid && lat < 5) begin cycle(); lat++; end
      check_val("xpose_elem1", DW'(state_out[1*W +: W]), DW'(8'h04));
      check_val("xpose_elem4", DW'(state_out[4*W +: W]), DW'(8'h01));
      drain();

      // Random keys everywhere, plus writes to unused addresses.
      for (int i = 0; i < 16; i++) begin
         key_we = 1; key_addr = AW'(i); key = rand_blk();
         cycle();
      end
      key_we = 0;

      // 12 back-to-back blocks from round 0.
      t0 = n_take; l0 = n_last;
      for (int i = 0; i < 12; i++) begin
         restart = (i == 0); in_valid = 1; state = rand_blk();
         cycle();
      end
      drain();
      check_val("b2b_results", DW'(n_take - t0), DW'(12));
      check_val("b2b_last_count", DW'(n_last - l0), DW'(1));

      // Output stall: results hold, input blocks, order kept.
      in_valid = 1; state = rand_blk();
      cycle();
      out_ready = 0; state = rand_blk();
      cycle();
      held = state_out;
      for (int i = 0; i < 2; i++) begin
         cycle();
         check_val("stall_hold", state_out, held);
         check_val("stall_valid", DW'(out_valid), DW'(1));
      end
      check_val("stall_in_ready", DW'(in_ready), DW'(0));
      out_ready = 1;
      cycle();
      state = rand_blk();
      cycle();
      drain();

      // Key write colliding with acceptance at round 2, then reuse after wrap.
      newkey = rand_blk();
      for (int i = 0; i < 14; i++) begin
         restart = (i == 0); in_valid = 1; state = rand_blk();
         key_we = (i == 2); key_addr = AW'(2); key = newkey;
         cycle();
      end
      drain();
      key_we = 1; key_addr = AW'(11); key = rand_blk();
      cycle();
      key_we = 0;
      for (int i = 0; i < N; i++) begin
         restart = (i == 0); in_valid = 1; state = rand_blk();
         cycle();
      end
      drain();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         enable    = ($urandom_range(0, 9) != 0);
         restart   = ($urandom_range(0, 19) == 0);
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         key_we    = ($urandom_range(0, 7) == 0);
         key_addr  = AW'($urandom_range(0, 15));
         key       = rand_blk();
         state     = rand_blk();
         cycle();
      end
      enable = 1;
      drain();

      // Reset with a pending result and competing controls.
      out_ready = 0; in_valid = 1; state = rand_blk();
      cycle();
      cycle();
      rst = 1; restart = 1; key_we = 1; key_addr = AW'(3); key = rand_blk();
      cycle();
      rst = 0; idle_inputs(); out_ready = 1;
      check_val("rst2_out_valid", DW'(out_valid), DW'(0));
      check_val("rst2_state_out", state_out, '0);
      check_val("rst2_out_round", DW'(out_round), DW'(0));
      check_val("rst2_out_last", DW'(out_last), DW'(0));
      for (int i = 0; i < N; i++) begin
         in_valid = 1; state = rand_blk();
         cycle();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
